// File: rtl/dsp_mac_sequencer_if.sv
// Operand-stream and result-stream handshake bundle for dsp_mac_sequencer.
// The sequencer uses the slave view; whatever feeds operands and drains results uses master.
interface dsp_mac_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;
    logic        res_cy;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_cy
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_cy
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Control stage for a DSP48A1 slice: streams operand pairs, tags every slot with an OPMODE
// and returns the accumulated P with a carry that stays set once any slot carries.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// FEED  | accepting the remaining beats; empty cycles issue HOLD
// DRAIN | last beat taken, waiting for its product to reach P
// HOLD  | result presented until the consumer takes it
module dsp_mac_sequencer #(
    parameter int N_TAPS     = 8,
    parameter int CNT_W      = 10,
    parameter int RESULT_LAT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    dsp_mac_sequencer_if.slave io_bus,
    output logic [17:0]        o_dsp_a,
    output logic [17:0]        o_dsp_b,
    output logic [7:0]         o_dsp_opmode,
    input  logic [47:0]        i_dsp_p,
    input  logic               i_dsp_carryout
);
    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h08;
    localparam int         DRN_W    = ($clog2(RESULT_LAT) > 0) ? $clog2(RESULT_LAT) : 1;

    if (N_TAPS < 2 || N_TAPS > 1024) begin : g_chk_taps
        $error("dsp_mac_sequencer: N_TAPS must lie in 2..1024");
    end
    if ((2 ** CNT_W) < N_TAPS) begin : g_chk_cnt
        $error("dsp_mac_sequencer: CNT_W too narrow for N_TAPS");
    end
    if (RESULT_LAT < 2) begin : g_chk_lat
        $error("dsp_mac_sequencer: RESULT_LAT must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_HOLD} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [DRN_W-1:0] r_drain;
    logic [7:0]       r_tag_pipe [RESULT_LAT];
    logic             r_cy;

    logic             w_accept;
    logic             w_last_beat;
    logic             w_drain_tc;
    logic             w_res_hs;
    logic             w_cy_slot;
    logic [7:0]       w_tag;

    assign w_accept    = io_bus.in_valid && io_bus.in_ready;
    assign w_last_beat = (r_state == S_FEED) && (r_cnt == CNT_W'(N_TAPS - 1));
    assign w_drain_tc  = (r_drain == '0);
    assign w_res_hs    = io_bus.res_valid && io_bus.res_ready;
    assign w_tag       = !w_accept ? OP_HOLD : ((r_state == S_IDLE) ? OP_FIRST : OP_ACC);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_FEED;
            S_FEED:  if (w_accept && w_last_beat) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_tc) w_next = S_HOLD;
            S_HOLD:  if (w_res_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        io_bus.in_ready  = 1'b0;
        io_bus.res_valid = 1'b0;
        case (r_state)
            S_IDLE, S_FEED: io_bus.in_ready  = !i_rst;
            S_HOLD:         io_bus.res_valid = 1'b1;
            default:        ;
        endcase
    end

    // DRAIN lasts RESULT_LAT-1 cycles so HOLD lines up with the final P.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_drain <= '0;
        end else begin
            if (w_accept) begin
                if (r_state == S_IDLE) begin
                    r_cnt <= CNT_W'(1);
                end else if (w_last_beat) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_accept && w_last_beat) begin
                r_drain <= DRN_W'(RESULT_LAT - 2);
            end else if (r_state == S_DRAIN && !w_drain_tc) begin
                r_drain <= r_drain - DRN_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dsp_a <= '0;
            o_dsp_b <= '0;
        end else if (w_accept) begin
            o_dsp_a <= io_bus.in_a;
            o_dsp_b <= io_bus.in_b;
        end
    end

    // Stage k carries the tag issued k+1 cycles ago; stage 1 meets the slice's OPMODEREG.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < RESULT_LAT; k++) begin
                r_tag_pipe[k] <= OP_HOLD;
            end
        end else begin
            r_tag_pipe[0] <= w_tag;
            for (int k = 1; k < RESULT_LAT; k++) begin
                r_tag_pipe[k] <= r_tag_pipe[k-1];
            end
        end
    end

    assign o_dsp_opmode = r_tag_pipe[1];
    assign w_cy_slot    = (r_tag_pipe[RESULT_LAT-1] != OP_HOLD) && i_dsp_carryout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cy <= 1'b0;
        end else if (w_accept && r_state == S_IDLE) begin
            r_cy <= 1'b0;
        end else if (w_cy_slot) begin
            r_cy <= 1'b1;
        end
    end

    // The final slot's carry arrives with res_valid, so it is folded in combinationally.
    assign io_bus.res_data = i_dsp_p;
    assign io_bus.res_cy   = r_cy | w_cy_slot;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP48A1 slice closes the loop, and a
// per-cycle reference built from accept times and plain sums predicts every output.
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;
    localparam int         N_TAPS = 4;
    localparam int         RLAT   = 4;
    localparam int         MAXC   = 4096;
    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h08;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsp_mac_sequencer_if bus ();
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_op;
    logic [47:0] dsp_p;
    logic        dsp_cy;

    dsp_mac_sequencer #(.N_TAPS(N_TAPS), .CNT_W(10), .RESULT_LAT(RLAT)) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .io_bus         (bus),
        .o_dsp_a        (dsp_a),
        .o_dsp_b        (dsp_b),
        .o_dsp_opmode   (dsp_op),
        .i_dsp_p        (dsp_p),
        .i_dsp_carryout (dsp_cy)
    );

    // Slice model: A1/B1 -> M -> P with registered OPMODE and CARRYOUT.
    logic [17:0] s_a1 = '0;
    logic [17:0] s_b1 = '0;
    logic [35:0] s_m  = '0;
    logic [7:0]  s_op = OP_HOLD;
    logic [47:0] s_p  = '0;
    logic        s_cy = 1'b0;
    logic        inj_now = 1'b0;

    always @(posedge clk) begin
        s_a1 <= dsp_a;
        s_b1 <= dsp_b;
        s_m  <= s_a1 * s_b1;
        s_op <= dsp_op;
        case (s_op)
            OP_FIRST: begin s_p <= {12'd0, s_m}; s_cy <= 1'b0; end
            OP_ACC:   {s_cy, s_p} <= {1'b0, s_p} + {13'd0, s_m};
            default:  s_cy <= 1'b0;
        endcase
    end
    assign dsp_p  = s_p;
    assign dsp_cy = s_cy | inj_now;

    typedef struct {
        logic [17:0] a;
        logic [17:0] b;
        bit          inj;
        int          gap;
    } beat_t;

    beat_t       q[$];
    logic [7:0]  exp_op [MAXC];
    bit          inj_at [MAXC];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          frame_cnt = 0;
    logic [47:0] acc_sum = '0;
    bit          acc_cy = 1'b0;
    bit          pending = 1'b0;
    int          res_due = 0;
    logic [47:0] exp_res = '0;
    bit          exp_rcy = 1'b0;
    logic [17:0] exp_a = '0;
    logic [17:0] exp_b = '0;
    int          n_res = 0;
    logic [47:0] last_res = '0;
    logic        last_cy = 1'b0;
    int          rr_delay = -1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input logic [17:0] a, input logic [17:0] b, input bit inj, input int gap);
        beat_t e;
        e.a = a; e.b = b; e.inj = inj; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic drive_cycle(input bit rst_v);
        bit          acc_now;
        bit          exp_rv;
        bit          exp_ir;
        logic [48:0] sum49;
        logic [47:0] prod;
        @(negedge clk);
        if (cyc > MAXC - 8) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 8);
            $fatal(1, "cycle budget exhausted");
        end
        rst          = rst_v;
        inj_now      = inj_at[cyc];
        bus.in_valid = (q.size() > 0) && (q[0].gap == 0) && !rst_v;
        bus.in_a     = (q.size() > 0) ? q[0].a : 18'($urandom);
        bus.in_b     = (q.size() > 0) ? q[0].b : 18'($urandom);
        bus.res_ready = (rr_delay < 0) ? 1'b1 : (pending && (cyc >= res_due + rr_delay));
        #1;
        exp_ir = !rst_v && !pending;
        exp_rv = !rst_v && pending && (cyc >= res_due);
        check_val("in_ready", bus.in_ready, exp_ir);
        if (!rst_v) begin
            check_val("res_valid", bus.res_valid, exp_rv);
            check_val("opmode", dsp_op, exp_op[cyc]);
            check_val("dsp_a", dsp_a, exp_a);
            check_val("dsp_b", dsp_b, exp_b);
            if (exp_rv) begin
                check_val("res_data", bus.res_data, exp_res);
                check_val("res_cy", bus.res_cy, exp_rcy);
            end
        end
        acc_now = bus.in_valid && exp_ir;
        if (rst_v) begin
            pending   = 1'b0;
            frame_cnt = 0;
            exp_a     = '0;
            exp_b     = '0;
            for (int c = cyc + 1; c <= cyc + RLAT + 1; c++) begin
                exp_op[c] = OP_HOLD;
                inj_at[c] = 1'b0;
            end
        end else begin
            if (exp_rv && bus.res_ready) begin
                pending  = 1'b0;
                n_res++;
                last_res = bus.res_data;
                last_cy  = bus.res_cy;
            end
            if (acc_now) begin
                prod = 48'(q[0].a) * 48'(q[0].b);
                if (frame_cnt == 0) begin
                    acc_sum = prod;
                    acc_cy  = q[0].inj;
                    exp_op[cyc + 2] = OP_FIRST;
                end else begin
                    sum49   = {1'b0, acc_sum} + {1'b0, prod};
                    acc_sum = sum49[47:0];
                    acc_cy  = acc_cy | sum49[48] | q[0].inj;
                    exp_op[cyc + 2] = OP_ACC;
                end
                if (q[0].inj) inj_at[cyc + RLAT] = 1'b1;
                exp_a = q[0].a;
                exp_b = q[0].b;
                frame_cnt++;
                if (frame_cnt == N_TAPS) begin
                    pending   = 1'b1;
                    res_due   = cyc + RLAT;
                    exp_res   = acc_sum;
                    exp_rcy   = acc_cy;
                    frame_cnt = 0;
                end
                void'(q.pop_front());
            end else if (q.size() > 0 && q[0].gap > 0) begin
                q[0].gap = q[0].gap - 1;
            end
        end
        cyc++;
    endtask

    task automatic run_until(input int target, input int bound);
        int k = 0;
        while (n_res < target && k < bound) begin
            drive_cycle(1'b0);
            k++;
        end
        check_val("frame_done", n_res, target);
    endtask

    task automatic push_basic();
        push(18'd1, 18'd2, 1'b0, 0);
        push(18'd3, 18'd4, 1'b0, 0);
        push(18'd5, 18'd6, 1'b0, 0);
        push(18'd7, 18'd8, 1'b0, 0);
    endtask

    initial begin
        int k;
        for (int c = 0; c < MAXC; c++) begin
            exp_op[c] = OP_HOLD;
            inj_at[c] = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        repeat (3) drive_cycle(1'b1);

        push_basic();
        run_until(1, 100);
        check_val("basic_sum", last_res, 48'd100);
        check_val("basic_cy", last_cy, 1'b0);

        push(18'd1, 18'd2, 1'b0, 0);
        push(18'd3, 18'd4, 1'b0, 0);
        push(18'd5, 18'd6, 1'b0, 2);
        push(18'd7, 18'd8, 1'b0, 0);
        run_until(2, 100);
        check_val("bubble_sum", last_res, 48'd100);

        rr_delay = 5;
        push_basic();
        run_until(3, 100);
        check_val("bp_sum", last_res, 48'd100);
        rr_delay = -1;

        push_basic();
        repeat (4) push(18'd10, 18'd10, 1'b0, 0);
        run_until(5, 200);
        check_val("b2b_sum", last_res, 48'd400);

        push(18'h3FFFF, 18'h3FFFF, 1'b0, 0);
        push(18'h3FFFF, 18'h3FFFF, 1'b1, 0);
        push(18'h3FFFF, 18'h3FFFF, 1'b0, 0);
        push(18'h3FFFF, 18'h3FFFF, 1'b0, 0);
        run_until(6, 100);
        check_val("cy_set", last_cy, 1'b1);
        push_basic();
        run_until(7, 100);
        check_val("cy_clear", last_cy, 1'b0);

        repeat (4) push(18'd3, 18'd5, 1'b0, 0);
        k = 0;
        while (frame_cnt < 2 && k < 50) begin
            drive_cycle(1'b0);
            k++;
        end
        check_val("rst_setup", frame_cnt, 2);
        drive_cycle(1'b1);
        q.delete();
        drive_cycle(1'b0);
        check_val("rst_opmode", dsp_op, OP_HOLD);
        check_val("rst_res_valid", bus.res_valid, 1'b0);
        repeat (4) push(18'd1, 18'd1, 1'b0, 0);
        run_until(8, 100);
        check_val("post_rst_sum", last_res, 48'd4);

        for (int f = 0; f < 25; f++) begin
            rr_delay = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            for (int b = 0; b < N_TAPS; b++) begin
                push(18'($urandom), 18'($urandom), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
            run_until(9 + f, 200);
        end
        rr_delay = -1;
        repeat (3) drive_cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
